wb_reg_file: RTL and testbench
==============================

# wb_reg_file

Writeback-stage register file for the 5-stage RV32 pipeline. It receives the MEM/WB pipeline register outputs, selects the writeback value (memory load data or ALU result), and commits it to a 32 x 32-bit architectural register file on the clock edge. It also serves the decode stage's two combinational read ports with write-first bypass, so an instruction in ID sees a value being written back in the same cycle. A third read port is provided for debug and testbench inspection.

## Interface

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; address width is 5 bits.

Ports:
- clock  input  1  single pipeline clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- WB_reg_write  input  1  writeback enable from MEM/WB.
- WB_mem_to_reg  input  1  1 selects read_data, 0 selects ALU_result.
- read_data  input  32  load data from MEM/WB.
- ALU_result  input  32  ALU result from MEM/WB.
- rd  input  5  destination register from MEM/WB.
- rs1  input  5  ID-stage source register 1 address.
- rs2  input  5  ID-stage source register 2 address.
- dbg_addr  input  5  debug read address.
- rs1_data  output  32  register rs1 value, bypassed.
- rs2_data  output  32  register rs2 value, bypassed.
- wb_data  output  32  selected writeback value, driven to the forwarding mux in EX.
- wb_valid  output  1  1 when a write to a non-zero register is being committed this cycle.
- dbg_data  output  32  register dbg_addr value, committed state only, not bypassed.

## Operation

- wb_data = WB_mem_to_reg ? read_data : ALU_result. This is combinational and is always driven, independent of WB_reg_write.
- wb_valid = WB_reg_write && (rd != 0) && !reset.
- Write rule: on a rising edge where wb_valid is 1, regs[rd] <= wb_data. No other register changes.
- x0 rule: register 0 is never written and always reads as 0 on every port, including through the bypass.
- Read ports rs1 and rs2 are combinational:
  - If wb_valid is 1 and rsN equals rd, rsN_data = wb_data (write-first bypass).
  - Otherwise, if rsN = 0, rsN_data = 0.
  - Otherwise, rsN_data = regs[rsN].
- Both read ports may bypass in the same cycle when rs1 = rs2 = rd.
- Reset: on a rising edge with reset = 1, all registers 1..31 are cleared to 0. Any write presented in that same cycle is discarded.
- While reset is high, rs1_data, rs2_data and dbg_data are forced to 0. wb_data still follows its inputs.

## Timing

- Write latency: the new value is visible in dbg_data, and in un-bypassed reads, in the cycle after the write edge.
- Bypass latency: zero cycles. rsN_data reflects wb_data combinationally in the same cycle the write is presented.
- Reset values: every register is 0. Outputs rs1_data, rs2_data, dbg_data and wb_valid are 0 while reset is high. wb_data is combinational from inputs and has no reset value.
- Reset mid-stream: if reset is asserted in cycle N, the write pending in cycle N is lost. The first write accepted is the one presented in the first cycle with reset = 0.
- Back-to-back writes to the same rd: the last edge wins. A read in the cycle of the second write returns the second value through the bypass.
- Write disabled (WB_reg_write = 0) with rd equal to rs1: no bypass, and the stored value is returned.
- The block has no stall or handshake. Every edge with wb_valid = 1 commits, and stalling is handled upstream by holding MEM/WB.

## Test plan

- Reset clear: preload x5 = 32'hDEADBEEF, assert reset for 1 cycle, then read dbg_addr = 5. Required: dbg_data = 0 and all 31 registers read 0.
- Mux and commit: write rd = 7 with ALU_result = 32'h1234 and WB_mem_to_reg = 0, then rd = 8 with read_data = 32'hCAFE and WB_mem_to_reg = 1. Required next cycle: x7 = 32'h1234 and x8 = 32'hCAFE.
- Bypass: with x3 = 32'h11, present a write of rd = 3, value 32'h22, with rs1 = rs2 = 3. Required same cycle: rs1_data = rs2_data = 32'h22 and dbg_data(3) = 32'h11. Required next cycle: dbg_data(3) = 32'h22.
- x0 protection: write rd = 0 with value 32'hFFFFFFFF and rs1 = 0. Required: wb_valid = 0, rs1_data = 0 in the same and next cycle, and dbg_data(0) = 0.
- Disabled write: set WB_reg_write = 0, rd = 4, ALU_result = 32'h99, with x4 = 32'h5 and rs2 = 4. Required: rs2_data = 32'h5 and x4 stays 32'h5.
- Reset collision: present a write of rd = 9, value 32'hAA, in the same cycle that reset = 1. Required: x9 = 0 after the edge, and rs1_data = 0 during that cycle with rs1 = 9.

Source files
------------

// File: rtl/wb_reg_file.sv
// Writeback-stage register file: selects the writeback value, commits it to the
// architectural registers and serves two bypassed decode read ports plus a debug port.
module wb_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            WB_reg_write,
    input  logic            WB_mem_to_reg,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] ALU_result,
    input  logic [AW-1:0]   rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_valid,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] r_regs [NREGS];

    logic [XLEN-1:0] w_wbData;
    logic            w_wbValid;
    logic            w_rs1Hit;
    logic            w_rs2Hit;

    assign w_wbData  = WB_mem_to_reg ? read_data : ALU_result;
    assign w_wbValid = WB_reg_write && (rd != '0) && !reset;

    assign w_rs1Hit = w_wbValid && (rs1 == rd);
    assign w_rs2Hit = w_wbValid && (rs2 == rd);

    // Reset takes priority over a write presented in the same cycle; x0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbValid) begin
            r_regs[rd] <= w_wbData;
        end
    end

    // Write-first bypass so ID sees the value committing on this edge.
    always_comb begin
        rs1_data = '0;
        if (reset) begin
            rs1_data = '0;
        end else if (w_rs1Hit) begin
            rs1_data = w_wbData;
        end else if (rs1 != '0) begin
            rs1_data = r_regs[rs1];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (reset) begin
            rs2_data = '0;
        end else if (w_rs2Hit) begin
            rs2_data = w_wbData;
        end else if (rs2 != '0) begin
            rs2_data = r_regs[rs2];
        end
    end

    // Debug port shows committed state only.
    always_comb begin
        dbg_data = '0;
        if (!reset && (dbg_addr != '0)) begin
            dbg_data = r_regs[dbg_addr];
        end
    end

    assign wb_data  = w_wbData;
    assign wb_valid = w_wbValid;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: a reference register model predicts each
// cycle's outputs into a scoreboard queue that is drained once the DUT settles.
module tb_wb_reg_file;

    logic        clock;
    logic        reset;
    logic        WB_reg_write;
    logic        WB_mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] ALU_result;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] dbg_data;

    wb_reg_file #(.XLEN(32), .NREGS(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .WB_reg_write (WB_reg_write),
        .WB_mem_to_reg(WB_mem_to_reg),
        .read_data    (read_data),
        .ALU_result   (ALU_result),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .dbg_addr     (dbg_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_data      (wb_data),
        .wb_valid     (wb_valid),
        .dbg_data     (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] expVal;
    } sbEntryT;

    sbEntryT     sbQueue[$];
    logic [31:0] modelRegs [32];
    int          compareCount  = 0;
    int          mismatchCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] readModel(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'h0 : modelRegs[addr];
    endfunction

    // Drives one cycle (called #1 after a rising edge), predicts, checks, then advances.
    task automatic applyStimulus(input string name, input logic rst, input logic we, input logic m2r,
                                 input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rdA,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbgA);
        logic [31:0] expWb;
        logic        expValid;
        logic [31:0] expR1;
        logic [31:0] expR2;
        logic [31:0] expDbg;
        sbEntryT     item;
        logic [31:0] observed;

        reset         = rst;
        WB_reg_write  = we;
        WB_mem_to_reg = m2r;
        read_data     = rdata;
        ALU_result    = alu;
        rd            = rdA;
        rs1           = r1;
        rs2           = r2;
        dbg_addr      = dbgA;

        expWb    = m2r ? rdata : alu;
        expValid = we && (rdA != 5'd0) && !rst;
        expR1    = rst ? 32'h0 : ((expValid && r1 == rdA) ? expWb : readModel(r1));
        expR2    = rst ? 32'h0 : ((expValid && r2 == rdA) ? expWb : readModel(r2));
        expDbg   = rst ? 32'h0 : readModel(dbgA);

        sbQueue.push_back('{0, {name, ".rs1_data"}, expR1});
        sbQueue.push_back('{1, {name, ".rs2_data"}, expR2});
        sbQueue.push_back('{2, {name, ".wb_data"},  expWb});
        sbQueue.push_back('{3, {name, ".wb_valid"}, {31'h0, expValid}});
        sbQueue.push_back('{4, {name, ".dbg_data"}, expDbg});

        #3;
        while (sbQueue.size() > 0) begin
            item = sbQueue.pop_front();
            case (item.sel)
                0:       observed = rs1_data;
                1:       observed = rs2_data;
                2:       observed = wb_data;
                3:       observed = {31'h0, wb_valid};
                default: observed = dbg_data;
            endcase
            checkOutput(item.tag, observed, item.expVal);
        end

        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        end else if (expValid) begin
            modelRegs[rdA] = expWb;
        end
        #1;
    endtask

    task automatic idleCycle(input string name, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbgA);
        applyStimulus(name, 1'b0, 1'b0, $urandom_range(0, 1), $urandom, $urandom, 5'($urandom_range(0, 31)), r1, r2, dbgA);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        reset = 1'b1; WB_reg_write = 1'b0; WB_mem_to_reg = 1'b0;
        read_data = '0; ALU_result = '0; rd = '0; rs1 = '0; rs2 = '0; dbg_addr = '0;
        @(posedge clock);
        #1;

        applyStimulus("rst0", 1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd5, 5'd5, 5'd5, 5'd5);

        // Reset clear
        applyStimulus("pre5", 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd1, 5'd2, 5'd5);
        idleCycle("see5", 5'd5, 5'd0, 5'd5);
        applyStimulus("rst1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 5'd5);
        for (int i = 0; i < 32; i++) idleCycle($sformatf("clr%0d", i), 5'(i), 5'(31 - i), 5'(i));

        // Mux and commit
        applyStimulus("w7", 1'b0, 1'b1, 1'b0, 32'h5555, 32'h1234, 5'd7, 5'd1, 5'd2, 5'd7);
        applyStimulus("w8", 1'b0, 1'b1, 1'b1, 32'hCAFE, 32'h6666, 5'd8, 5'd7, 5'd1, 5'd7);
        idleCycle("rd78", 5'd7, 5'd8, 5'd8);

        // Bypass
        applyStimulus("w3a", 1'b0, 1'b1, 1'b0, 32'h0, 32'h11, 5'd3, 5'd0, 5'd0, 5'd3);
        applyStimulus("byp3", 1'b0, 1'b1, 1'b1, 32'h22, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3);
        idleCycle("aft3", 5'd3, 5'd3, 5'd3);

        // x0 protection
        applyStimulus("w0", 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        idleCycle("aft0", 5'd0, 5'd0, 5'd0);

        // Disabled write
        applyStimulus("w4", 1'b0, 1'b1, 1'b0, 32'h0, 32'h5, 5'd4, 5'd0, 5'd0, 5'd4);
        applyStimulus("dis4", 1'b0, 1'b0, 1'b0, 32'h0, 32'h99, 5'd4, 5'd4, 5'd4, 5'd4);
        idleCycle("aft4", 5'd4, 5'd4, 5'd4);

        // Reset collision
        applyStimulus("w9", 1'b0, 1'b1, 1'b0, 32'h0, 32'h55, 5'd9, 5'd0, 5'd0, 5'd9);
        applyStimulus("col9", 1'b1, 1'b1, 1'b0, 32'h0, 32'hAA, 5'd9, 5'd9, 5'd9, 5'd9);
        idleCycle("aft9", 5'd9, 5'd9, 5'd9);

        // Back-to-back writes to the same register
        applyStimulus("b2bA", 1'b0, 1'b1, 1'b0, 32'h0, 32'h1, 5'd10, 5'd10, 5'd0, 5'd10);
        applyStimulus("b2bB", 1'b0, 1'b1, 1'b1, 32'h2, 32'h0, 5'd10, 5'd10, 5'd10, 5'd10);
        idleCycle("aftB", 5'd10, 5'd9, 5'd10);

        for (int i = 0; i < 60; i++) begin
            applyStimulus($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom, $urandom, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
